// File: rtl/west_pp_buffer_pkg.sv
// ---------------------------------------------------------------------------
// west_pp_buffer_pkg
// Shared definitions for the west-operand ping-pong buffer:
//   bank_state_t : lifecycle of one bank (EMPTY -> FILLING -> FULL -> DRAINING)
//   calc_data_w  : width of one buffer word, WIDTH*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B
// ---------------------------------------------------------------------------
package west_pp_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    function automatic int calc_data_w(input int width, input int chunk_size,
                                       input int cores_a, input int cores_b);
        return width * chunk_size * cores_a * cores_b;
    endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// ---------------------------------------------------------------------------
// pp_bank_ram
// Simple dual-port RAM holding one ping-pong bank. One write port, one read
// port with a registered read (data appears the cycle after i_re). The read
// register holds its value while i_re is low, which the buffer relies on to
// stall its read pipeline. Contents are not reset.
// Ports:
//   i_clk              clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr       read request
//   o_rdata            registered read data
// ---------------------------------------------------------------------------
module pp_bank_ram #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/west_pp_buffer.sv
// ---------------------------------------------------------------------------
// west_pp_buffer
// Two-bank ping-pong buffer feeding the west operand of a systolic array.
// The upstream projection fills one bank while the other bank is replayed
// REPLAY times (once per north column block) towards the array.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready/in_data      write stream (DATA_W bits per word)
//   out_valid/out_ready/out_data   west feed (DATA_W bits per word)
//   out_pass_end                   word DEPTH-1 of every pass
//   out_last                       word DEPTH-1 of the final pass
//   bank_full[1:0]                 bank is FULL or DRAINING
//   stall_cnt[31:0]                only with WEST_PP_STALL_CNT_EN defined:
//                                  saturating count of out_ready&!out_valid
//
// Read path: issue (address/pass counters) -> _p1 RAM read register ->
// _p2 output register. Both stages advance together whenever the output
// register is empty or being accepted.
// ---------------------------------------------------------------------------
module west_pp_buffer
    import west_pp_buffer_pkg::*;
#(
    parameter  int WIDTH       = 16,
    parameter  int CHUNK_SIZE  = 4,
    parameter  int NUM_CORES_A = 2,
    parameter  int NUM_CORES_B = 2,
    parameter  int DEPTH       = 64,
    parameter  int REPLAY      = 4,
    localparam int DATA_W      = calc_data_w(WIDTH, CHUNK_SIZE, NUM_CORES_A, NUM_CORES_B)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_pass_end,
    output logic              out_last,
    output logic [1:0]        bank_full
`ifdef WEST_PP_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              PW        = $clog2(REPLAY) + 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PW-1:0]   LAST_PASS = PW'(REPLAY - 1);

    bank_state_t       r_state [2];
    bank_state_t       w_state_nxt [2];

    logic              r_wr_bank;
    logic [AW-1:0]     r_wr_addr;
    logic              r_rd_bank;     // bank whose words are leaving the output register
    logic              r_iss_bank;    // bank the read counters are walking
    logic              r_iss_active;
    logic [AW-1:0]     r_rd_addr;
    logic [PW-1:0]     r_pass;

    logic              r_rd_vld_p1;
    logic              r_rd_sel_p1;
    logic              r_rd_pass_end_p1;
    logic              r_rd_last_p1;

    logic              r_out_valid_p2;
    logic              r_out_pass_end_p2;
    logic              r_out_last_p2;
    logic [DATA_W-1:0] r_out_data_p2;

    logic              w_wr_fire;
    logic              w_wr_last;
    logic              w_adv;
    logic              w_rd_en;
    logic              w_start;
    logic              w_rd_pass_end;
    logic              w_rd_last;
    logic              w_out_fire;
    logic              w_release;
    logic [1:0]        w_we;
    logic [1:0]        w_re;
    logic [DATA_W-1:0] w_rdata [2];
    logic [DATA_W-1:0] w_rd_data_p1;

    assign w_wr_fire     = in_valid && in_ready;
    assign w_wr_last     = w_wr_fire && (r_wr_addr == LAST_ADDR);
    assign w_adv         = !r_out_valid_p2 || out_ready;
    // A FULL bank is only claimed when the pipeline can take its first word,
    // so DRAINING always implies the address-0 read has been issued.
    assign w_rd_en       = w_adv && (r_iss_active || (r_state[r_iss_bank] == FULL));
    assign w_start       = w_rd_en && !r_iss_active;
    assign w_rd_pass_end = (r_rd_addr == LAST_ADDR);
    assign w_rd_last     = w_rd_pass_end && (r_pass == LAST_PASS);
    assign w_out_fire    = r_out_valid_p2 && out_ready;
    assign w_release     = w_out_fire && r_out_last_p2;

    always_comb begin
        w_we = '0;
        w_re = '0;
        w_we[r_wr_bank]  = w_wr_fire;
        w_re[r_iss_bank] = w_rd_en;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pp_bank_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_ram (
            .i_clk   (clk),
            .i_we    (w_we[b]),
            .i_waddr (r_wr_addr),
            .i_wdata (in_data),
            .i_re    (w_re[b]),
            .i_raddr (r_rd_addr),
            .o_rdata (w_rdata[b])
        );
    end

    // Bank state machine: register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state[0] <= EMPTY;
            r_state[1] <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bank state machine: next state. Write, claim and release each need a
    // different source state, so they never collide on one bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_wr_fire && (r_wr_bank == 1'(b))) begin
                w_state_nxt[b] = w_wr_last ? FULL : FILLING;
            end
            if (w_start && (r_iss_bank == 1'(b))) begin
                w_state_nxt[b] = DRAINING;
            end
            if (w_release && (r_rd_bank == 1'(b))) begin
                w_state_nxt[b] = EMPTY;
            end
        end
    end

    // Bank state machine: outputs. in_ready comes from registered state, so a
    // bank released this cycle becomes writable only on the next one.
    always_comb begin
        bank_full = '0;
        in_ready  = (r_state[r_wr_bank] == EMPTY) || (r_state[r_wr_bank] == FILLING);
        for (int b = 0; b < 2; b++) begin
            bank_full[b] = (r_state[b] == FULL) || (r_state[b] == DRAINING);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_addr <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                if (r_wr_addr == LAST_ADDR) begin
                    r_wr_addr <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // ---- issue -> p1: read counters and RAM read register ----
    // The issue pointer moves on as soon as the last read of a bank is issued,
    // letting the next FULL bank start without a gap in the output stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_active     <= 1'b0;
            r_iss_bank       <= 1'b0;
            r_rd_addr        <= '0;
            r_pass           <= '0;
            r_rd_vld_p1      <= 1'b0;
            r_rd_sel_p1      <= 1'b0;
            r_rd_pass_end_p1 <= 1'b0;
            r_rd_last_p1     <= 1'b0;
        end else if (w_adv) begin
            r_rd_vld_p1 <= w_rd_en;
            if (w_rd_en) begin
                r_rd_sel_p1      <= r_iss_bank;
                r_rd_pass_end_p1 <= w_rd_pass_end;
                r_rd_last_p1     <= w_rd_last;
                if (w_rd_pass_end) begin
                    r_rd_addr <= '0;
                    if (w_rd_last) begin
                        r_pass       <= '0;
                        r_iss_active <= 1'b0;
                        r_iss_bank   <= ~r_iss_bank;
                    end else begin
                        r_pass       <= r_pass + 1'b1;
                        r_iss_active <= 1'b1;
                    end
                end else begin
                    r_rd_addr    <= r_rd_addr + 1'b1;
                    r_iss_active <= 1'b1;
                end
            end
        end
    end

    assign w_rd_data_p1 = w_rdata[r_rd_sel_p1];

    // ---- p1 -> p2: output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid_p2    <= 1'b0;
            r_out_pass_end_p2 <= 1'b0;
            r_out_last_p2     <= 1'b0;
        end else if (w_adv) begin
            r_out_valid_p2    <= r_rd_vld_p1;
            r_out_pass_end_p2 <= r_rd_vld_p1 && r_rd_pass_end_p1;
            r_out_last_p2     <= r_rd_vld_p1 && r_rd_last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv && r_rd_vld_p1) begin
            r_out_data_p2 <= w_rd_data_p1;
        end
    end

    assign out_valid    = r_out_valid_p2;
    assign out_data     = r_out_data_p2;
    assign out_pass_end = r_out_pass_end_p2;
    assign out_last     = r_out_last_p2;

`ifdef WEST_PP_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_ready && !r_out_valid_p2 && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_west_pp_buffer.sv
module tb_west_pp_buffer;

    localparam int WIDTH       = 8;
    localparam int CHUNK_SIZE  = 1;
    localparam int NUM_CORES_A = 1;
    localparam int NUM_CORES_B = 1;
    localparam int DEPTH       = 4;
    localparam int REPLAY      = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_pass_end;
    logic       out_last;
    logic [1:0] bank_full;
`ifdef WEST_PP_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    west_pp_buffer #(
        .WIDTH       (WIDTH),
        .CHUNK_SIZE  (CHUNK_SIZE),
        .NUM_CORES_A (NUM_CORES_A),
        .NUM_CORES_B (NUM_CORES_B),
        .DEPTH       (DEPTH),
        .REPLAY      (REPLAY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_pass_end (out_pass_end),
        .out_last     (out_last),
        .bank_full    (bank_full)
`ifdef WEST_PP_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if ({out_pass_end, out_last} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {out_pass_end, out_last}); end
        checks++;
        if (bank_full !== 2'b00) begin errors++; $display("FAIL reset_bank_full: got %b expected 00", bank_full); end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_pass();
        logic [7:0] exp;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL sp_latency_e0: got %b expected 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL sp_latency_e1: got %b expected 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL sp_latency_e2: got %b expected 1", out_valid); end
        for (int k = 0; k < 8; k++) begin
            exp = 8'(8'hA0 + (k % 4));
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                errors++; $display("FAIL sp_word%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, exp);
            end
            checks++;
            if (out_pass_end !== ((k % 4) == 3)) begin
                errors++; $display("FAIL sp_pass_end%0d: got %b expected %b", k, out_pass_end, ((k % 4) == 3));
            end
            checks++;
            if (out_last !== (k == 7)) begin
                errors++; $display("FAIL sp_last%0d: got %b expected %b", k, out_last, (k == 7));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL sp_after_valid: got %b expected 0", out_valid); end
        checks++;
        if (bank_full !== 2'b00) begin errors++; $display("FAIL sp_after_bank_full: got %b expected 00", bank_full); end
    endtask

    task automatic test_back_to_back();
        int acc;
        int n;
        bit seen_last;
        bit released;
        logic [7:0] exp;
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hB0 + acc);
            if (in_ready) acc++;
            tick();
        end
        in_data = 8'(8'hB0 + acc);
        checks++;
        if (acc != 8) begin errors++; $display("FAIL b2b_accepted: got %0d expected 8", acc); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (bank_full !== 2'b11) begin errors++; $display("FAIL b2b_bank_full: got %b expected 11", bank_full); end
        out_ready = 1'b1;
        n = 0; seen_last = 1'b0; released = 1'b0;
        for (int cyc = 0; cyc < 100 && n < 16; cyc++) begin
            if (seen_last && !released) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_release: got %b expected 1", in_ready); end
                released = 1'b1;
            end else if (released) begin
                in_valid = 1'b0;
            end
            if (!seen_last) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_early_accept cyc%0d: got %b expected 0", cyc, in_ready); end
            end
            if (out_valid && out_ready) begin
                exp = 8'(8'hB0 + (n / 8) * 4 + (n % 4));
                checks++;
                if (out_data !== exp) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", n, out_data, exp); end
                checks++;
                if (out_last !== ((n % 8) == 7)) begin errors++; $display("FAIL b2b_last%0d: got %b expected %b", n, out_last, ((n % 8) == 7)); end
                if (out_last && n < 8) seen_last = 1'b1;
                n++;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (n != 16) begin errors++; $display("FAIL b2b_drain_count: got %0d expected 16", n); end
        checks++;
        if (released !== 1'b1) begin errors++; $display("FAIL b2b_release_seen: got %b expected 1", released); end
    endtask

    task automatic test_toggle_ready();
        int n;
        bit stalled;
        logic [7:0] held;
        logic held_pe;
        bit dup;
        logic [7:0] exp;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + i);
            tick();
        end
        in_valid = 1'b0;
        n = 0; stalled = 1'b0; held = 8'h00; held_pe = 1'b0;
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held || out_pass_end !== held_pe) begin
                    errors++; $display("FAIL tog_stall_hold: got v=%b d=%h pe=%b expected v=1 d=%h pe=%b", out_valid, out_data, out_pass_end, held, held_pe);
                end
            end
            out_ready = ~out_ready;
            if (out_valid && out_ready) begin
                exp = 8'(8'hC0 + (n % 4));
                checks++;
                if (out_data !== exp) begin errors++; $display("FAIL tog_word%0d: got %h expected %h", n, out_data, exp); end
                n++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            held_pe = out_pass_end;
            tick();
        end
        checks++;
        if (n != 8) begin errors++; $display("FAIL tog_count: got %0d expected 8", n); end
        out_ready = 1'b1;
        dup = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) dup = 1'b1;
            tick();
        end
        checks++;
        if (dup !== 1'b0) begin errors++; $display("FAIL tog_no_dup: got extra valid %b expected 0", dup); end
    endtask

    task automatic test_reset_drain();
        int n;
        bit bad;
        logic [7:0] exp;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hD0 + i);
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
            if (out_valid && out_ready) begin
                exp = 8'(8'hD0 + n);
                checks++;
                if (out_data !== exp) begin errors++; $display("FAIL rd_word%0d: got %h expected %h", n, out_data, exp); end
                n++;
            end
            tick();
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL rd_pre_count: got %0d expected 3", n); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_async_valid: got %b expected 0", out_valid); end
        checks++;
        if (bank_full !== 2'b00) begin errors++; $display("FAIL rd_async_bank_full: got %b expected 00", bank_full); end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rd_in_ready: got %b expected 1", in_ready); end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL rd_no_output: got valid seen %b expected 0", bad); end
    endtask

    task automatic test_no_bubble();
        logic [7:0] exp;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hE0 + i);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp = 8'(8'hE0 + (k / 8) * 4 + (k % 4));
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                errors++; $display("FAIL nb_word%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, exp);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL nb_after_valid: got %b expected 0", out_valid); end
    endtask

`ifdef WEST_PP_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        out_ready = 1'b1;
        repeat (10) tick();
        out_ready = 1'b0;
        checks++;
        if (stall_cnt !== 32'd10) begin errors++; $display("FAIL stall_cnt: got %0d expected 10", stall_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        test_reset();
        test_single_pass();
        test_back_to_back();
        test_toggle_ready();
        test_reset_drain();
        test_no_bubble();
`ifdef WEST_PP_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
